// File: rtl/xbar_nxm_pkg.sv
// Shared crossbar sizing, ID types and the address-to-slave decode.
package xbar_nxm_pkg;

  localparam int N_MASTERS  = 4;
  localparam int N_SLAVES   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_OUTST  = 4;

  localparam int MID_W = $clog2(N_MASTERS);
  localparam int SID_W = $clog2(N_SLAVES);

  typedef logic [MID_W-1:0] mid_t;
  typedef logic [SID_W-1:0] sid_t;

  // The top address bits pick the slave; the address itself is never rewritten.
  function automatic sid_t addr2sid(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1 -: SID_W];
  endfunction

endpackage

// File: rtl/xbar_nxm_if.sv
// One side of the req/ack bus, NP ports wide; the crossbar uses one instance per side.
interface xbar_nxm_if #(
  parameter int NP = xbar_nxm_pkg::N_MASTERS,
  parameter int AW = xbar_nxm_pkg::ADDR_WIDTH,
  parameter int DW = xbar_nxm_pkg::DATA_WIDTH
);
  logic [NP-1:0]         req;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0]         cmd;
  logic [NP-1:0][DW-1:0] wdata;
  logic [NP-1:0]         ack;
  logic [NP-1:0][DW-1:0] rdata;
  logic [NP-1:0]         resp;

  modport master (output req, addr, cmd, wdata, input ack, rdata, resp);
  modport slave  (input req, addr, cmd, wdata, output ack, rdata, resp);
endinterface

// File: rtl/xbar_rr_arbiter.sv
// Locking round-robin arbiter: a grant is held until the cycle it is acknowledged.
module xbar_rr_arbiter #(
  parameter int N  = xbar_nxm_pkg::N_MASTERS,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          ack_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          gnt_valid_o
);
  import xbar_nxm_pkg::*;

  logic [IW-1:0] ptr_q, ptr_d, lock_id_q, lock_id_d;
  logic          lock_q, lock_d;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    gnt_o       = '0;
    ptr_d       = ptr_q;
    lock_d      = 1'b0;
    lock_id_d   = lock_id_q;
    if (lock_q && req_i[lock_id_q]) begin
      gnt_valid_o = 1'b1;
      gnt_id_o    = lock_id_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!gnt_valid_o && req_i[(int'(ptr_q) + k) % N]) begin
          gnt_valid_o = 1'b1;
          gnt_id_o    = IW'((int'(ptr_q) + k) % N);
        end
      end
    end
    if (gnt_valid_o) begin
      gnt_o[gnt_id_o] = 1'b1;
      if (ack_i) begin
        ptr_d = (gnt_id_o == IW'(N - 1)) ? '0 : gnt_id_o + 1'b1;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = gnt_id_o;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: rtl/xbar_nxm.sv
// N-master x M-slave crossbar with per-slave locking arbitration and in-order read-ID return.
module xbar_nxm #(
  parameter int N_MASTERS  = xbar_nxm_pkg::N_MASTERS,
  parameter int N_SLAVES   = xbar_nxm_pkg::N_SLAVES,
  parameter int ADDR_WIDTH = xbar_nxm_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = xbar_nxm_pkg::DATA_WIDTH,
  parameter int MAX_OUTST  = xbar_nxm_pkg::MAX_OUTST
) (
  input  logic       clk,
  input  logic       rst,
  xbar_nxm_if.slave  m_if,
  xbar_nxm_if.master s_if,
  output logic       proto_err_o
);
  import xbar_nxm_pkg::*;

  localparam int MW = $clog2(N_MASTERS);
  localparam int SW = $clog2(N_SLAVES);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = $clog2(N_SLAVES * MAX_OUTST + 1);

  logic [N_MASTERS-1:0][SW-1:0]       sid, tgt_q, tgt_d;
  logic [N_MASTERS-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [N_MASTERS-1:0]               blocked;
  logic [N_SLAVES-1:0][N_MASTERS-1:0] elig, gnt;
  logic [N_SLAVES-1:0][MW-1:0]        gnt_id, head;
  logic [N_SLAVES-1:0]                gnt_valid, fifo_full, fifo_empty, push, pop;
  logic                               err_q, err_d;

  // A master with reads in flight may only talk to the slave holding them.
  always_comb begin
    sid     = '0;
    blocked = '0;
    elig    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      sid[i]     = m_if.addr[i][ADDR_WIDTH-1 -: SW];
      blocked[i] = (cnt_q[i] != '0) && (tgt_q[i] != sid[i]);
    end
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        elig[j][i] = !rst && m_if.req[i] && (sid[i] == SW'(j)) && !blocked[i]
                     && !(fifo_full[j] && !m_if.cmd[i]);
      end
    end
  end

  for (genvar j = 0; j < N_SLAVES; j++) begin : g_slv
    logic [MW-1:0] mem_q [MAX_OUTST];
    logic [PW:0]   wr_q, rd_q;

    xbar_rr_arbiter #(.N(N_MASTERS), .IW(MW)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (elig[j]),
      .ack_i       (s_if.ack[j]),
      .gnt_o       (gnt[j]),
      .gnt_id_o    (gnt_id[j]),
      .gnt_valid_o (gnt_valid[j])
    );

    assign s_if.req[j]   = gnt_valid[j];
    assign s_if.addr[j]  = gnt_valid[j] ? m_if.addr[gnt_id[j]]  : '0;
    assign s_if.cmd[j]   = gnt_valid[j] ? m_if.cmd[gnt_id[j]]   : 1'b0;
    assign s_if.wdata[j] = gnt_valid[j] ? m_if.wdata[gnt_id[j]] : '0;

    // In-order ID FIFO: the head names the master owed the next read response.
    assign fifo_empty[j] = (wr_q == rd_q);
    assign fifo_full[j]  = ((wr_q - rd_q) == (PW+1)'(MAX_OUTST));
    assign push[j]       = gnt_valid[j] && s_if.ack[j] && !m_if.cmd[gnt_id[j]];
    assign pop[j]        = s_if.resp[j] && !fifo_empty[j];
    assign head[j]       = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push[j]) wr_q <= wr_q + 1'b1;
        if (pop[j])  rd_q <= rd_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push[j]) mem_q[wr_q[PW-1:0]] <= gnt_id[j];
    end
  end

  always_comb begin
    m_if.ack   = '0;
    m_if.resp  = '0;
    m_if.rdata = '0;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    err_d      = err_q;
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gnt[j][i] && s_if.ack[j]) m_if.ack[i] = 1'b1;
      end
      if (pop[j]) begin
        m_if.resp[head[j]]  = 1'b1;
        m_if.rdata[head[j]] = s_if.rdata[j];
      end
      if (s_if.resp[j] && fifo_empty[j]) err_d = 1'b1;
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (m_if.ack[i] && !m_if.cmd[i]) begin
        cnt_d[i] = cnt_d[i] + CW'(1);
        tgt_d[i] = sid[i];
      end
      if (m_if.resp[i]) cnt_d[i] = cnt_d[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tgt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      err_q <= err_d;
    end
  end

  assign proto_err_o = err_q;

endmodule

// File: tb/tb_xbar_nxm.sv
// Random traffic against a queue-based reference of the crossbar's arbitration and read-return rules.
module tb_xbar_nxm;
  import xbar_nxm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic protoErr;

  xbar_nxm_if #(.NP(N_MASTERS), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) mIf ();
  xbar_nxm_if #(.NP(N_SLAVES),  .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) sIf ();

  xbar_nxm dut (
    .clk         (clk),
    .rst         (rst),
    .m_if        (mIf),
    .s_if        (sIf),
    .proto_err_o (protoErr)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  // Reference state: per-slave pointer, held grant and queue of owed master IDs; per-master read count/target.
  int ptrM  [N_SLAVES];
  int lockM [N_SLAVES];
  int fifoM [N_SLAVES][$];
  int cntM  [N_MASTERS];
  int tgtM  [N_MASTERS];
  bit dropReq [N_MASTERS];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int rnd(input int n);
    return int'($urandom_range(n - 1));
  endfunction

  task automatic resetModel();
    for (int j = 0; j < N_SLAVES; j++) begin
      ptrM[j]  = 0;
      lockM[j] = -1;
      fifoM[j].delete();
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      cntM[i]    = 0;
      tgtM[i]    = 0;
      dropReq[i] = 1'b0;
    end
  endtask

  function automatic bit eligibleM(input int i, input int j);
    int s;
    s = int'(addr2sid(mIf.addr[i]));
    return mIf.req[i] && (s == j) && !(cntM[i] > 0 && tgtM[i] != j)
           && !(fifoM[j].size() == MAX_OUTST && !mIf.cmd[i]);
  endfunction

  task automatic applyStimulus(input int ackPct, input int respPct, input int readPct, input int focus);
    logic [ADDR_WIDTH-1:0] a;
    int slv;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (dropReq[i]) begin
        mIf.req[i] = 1'b0;
        dropReq[i] = 1'b0;
      end
      if (!mIf.req[i] && rnd(100) < 60) begin
        slv = (focus >= 0) ? focus : rnd(N_SLAVES);
        a = $urandom;
        a[ADDR_WIDTH-1 -: SID_W] = sid_t'(slv);
        mIf.req[i]   = 1'b1;
        mIf.addr[i]  = a;
        mIf.cmd[i]   = (rnd(100) >= readPct);
        mIf.wdata[i] = $urandom;
      end
    end
    for (int j = 0; j < N_SLAVES; j++) begin
      sIf.ack[j]   = (rnd(100) < ackPct);
      sIf.resp[j]  = (fifoM[j].size() > 0) ? (rnd(100) < respPct) : (rnd(100) < 3);
      sIf.rdata[j] = $urandom;
    end
  endtask

  task automatic evalCycle();
    int win [N_SLAVES];
    int h, w;
    logic [N_MASTERS-1:0] expAck, expResp;
    logic [DATA_WIDTH-1:0] expData [N_MASTERS];
    expAck  = '0;
    expResp = '0;
    for (int i = 0; i < N_MASTERS; i++) expData[i] = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      win[j] = -1;
      if (lockM[j] >= 0 && eligibleM(lockM[j], j)) begin
        win[j] = lockM[j];
      end else begin
        for (int k = 0; k < N_MASTERS; k++) begin
          if (win[j] < 0 && eligibleM((ptrM[j] + k) % N_MASTERS, j)) win[j] = (ptrM[j] + k) % N_MASTERS;
        end
      end
      checkOutput("s_req", 64'(sIf.req[j]), 64'(win[j] >= 0));
      if (win[j] >= 0) begin
        w = win[j];
        checkOutput("s_addr",  64'(sIf.addr[j]),  64'(mIf.addr[w]));
        checkOutput("s_cmd",   64'(sIf.cmd[j]),   64'(mIf.cmd[w]));
        checkOutput("s_wdata", 64'(sIf.wdata[j]), 64'(mIf.wdata[w]));
        if (sIf.ack[j]) expAck[w] = 1'b1;
      end
      if (sIf.resp[j] && fifoM[j].size() > 0) begin
        h = fifoM[j][0];
        expResp[h] = 1'b1;
        expData[h] = sIf.rdata[j];
      end
    end
    checkOutput("m_ack",  64'(mIf.ack),  64'(expAck));
    checkOutput("m_resp", 64'(mIf.resp), 64'(expResp));
    for (int i = 0; i < N_MASTERS; i++) begin
      if (expResp[i]) checkOutput("m_rdata", 64'(mIf.rdata[i]), 64'(expData[i]));
    end
    for (int j = 0; j < N_SLAVES; j++) begin
      if (sIf.resp[j] && fifoM[j].size() > 0) begin
        h = fifoM[j].pop_front();
        cntM[h]--;
      end
      if (win[j] >= 0 && sIf.ack[j]) begin
        w = win[j];
        ptrM[j]    = (w + 1) % N_MASTERS;
        lockM[j]   = -1;
        dropReq[w] = 1'b1;
        if (!mIf.cmd[w]) begin
          fifoM[j].push_back(w);
          cntM[w]++;
          tgtM[w] = j;
        end
      end else begin
        lockM[j] = win[j];
      end
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_s_req",  64'(sIf.req),  64'(0));
    checkOutput("rst_m_ack",  64'(mIf.ack),  64'(0));
    checkOutput("rst_m_resp", 64'(mIf.resp), 64'(0));
    checkOutput("rst_err",    64'(protoErr), 64'(0));
    for (int i = 0; i < N_MASTERS; i++) checkOutput("rst_m_rdata", 64'(mIf.rdata[i]), 64'(0));
  endtask

  task automatic runPhase(input int cycles, input int ackPct, input int respPct, input int readPct, input int focus);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      applyStimulus(ackPct, respPct, readPct, focus);
      #1;
      evalCycle();
    end
  endtask

  // Reset with requests and responses still active, then a stray response on empty FIFOs.
  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    sIf.resp = '1;
    sIf.ack  = '1;
    #1;
    checkResetOutputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mIf.req = '1;
      #1;
      checkResetOutputs();
    end
    resetModel();
    @(negedge clk);
    rst      = 1'b0;
    mIf.req  = '0;
    sIf.ack  = '0;
    sIf.resp = '1;
    #1;
    evalCycle();
  endtask

  initial begin
    rst       = 1'b1;
    mIf.req   = '0;
    mIf.addr  = '0;
    mIf.cmd   = '0;
    mIf.wdata = '0;
    sIf.ack   = '0;
    sIf.resp  = '0;
    sIf.rdata = '0;
    resetModel();
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst = 1'b0;

    runPhase(400, 70, 40, 50, -1);
    runPhase(200, 80, 3, 70, 2);
    runPhase(200, 60, 30, 50, 0);
    runPhase(100, 90, 2, 90, -1);
    pulseReset();
    runPhase(400, 50, 50, 50, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
